// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control unit: counter modes and the default
// loop counts used by the multiply/divide sequencers.
package alu_ctrl_pkg;

    localparam int CNT_WRAP      = 0;
    localparam int CNT_SAT       = 1;

    localparam int CNT_WIDTH_DEF = 3;
    localparam int MUL_LOOP_CNT  = 7;
    localparam int DIV_LOOP_CNT  = 7;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for multiply/divide loop control: up/down stepping with
// clear, load, wrap/saturate mode, a terminal pulse and a sticky done flag.
module iter_counter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF,
    parameter int N_REQ = 2,
    parameter int TERM  = MUL_LOOP_CNT,
    parameter int SAT   = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [N_REQ-1:0] req,
    input  logic             dn,
    output logic [WIDTH-1:0] cnt,
    output logic             at_term,
    output logic             tc_pulse,
    output logic             done
);

    localparam logic [WIDTH-1:0] TERM_V   = WIDTH'(TERM);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam bit               SAT_MODE = (SAT == CNT_SAT);

    logic             step;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             done_nxt;

    assign step    = |req;
    assign at_term = (cnt == TERM_V);

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt  = cnt;
        tc_nxt   = 1'b0;
        done_nxt = done;
        if (clr) begin
            cnt_nxt  = '0;
            done_nxt = 1'b0;
        end else if (load) begin
            cnt_nxt  = load_val;
            done_nxt = 1'b0;
        end else if (step) begin
            if (!dn) begin
                if (cnt == TERM_V) begin
                    cnt_nxt = SAT_MODE ? cnt : '0;
                end else if (SAT_MODE && cnt == ALL_ONES) begin
                    // Loaded above TERM and already at the top: hold, do not roll over.
                    cnt_nxt = cnt;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                if (cnt == '0) begin
                    cnt_nxt = SAT_MODE ? '0 : TERM_V;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            tc_nxt = (cnt_nxt == TERM_V) && (cnt != TERM_V);
            if (tc_nxt) begin
                done_nxt = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_pulse <= 1'b0;
            done     <= 1'b0;
        end else begin
            tc_pulse <= tc_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_iter_counter.sv
// Directed bench for iter_counter: a wrap instance (TERM=7) and a saturate
// instance (TERM=5) sharing clock and reset.
module tb_iter_counter;
    import alu_ctrl_pkg::*;

    logic       clk;
    logic       rst;

    logic       clr_a, load_a, dn_a;
    logic [2:0] load_val_a;
    logic [1:0] req_a;
    logic [2:0] cnt_a;
    logic       at_term_a, tc_pulse_a, done_a;

    logic       clr_b, load_b, dn_b;
    logic [2:0] load_val_b;
    logic [1:0] req_b;
    logic [2:0] cnt_b;
    logic       at_term_b, tc_pulse_b, done_b;

    int errors = 0;
    int checks = 0;

    iter_counter #(.WIDTH(3), .N_REQ(2), .TERM(7), .SAT(CNT_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr_a), .load(load_a), .load_val(load_val_a),
        .req(req_a), .dn(dn_a), .cnt(cnt_a), .at_term(at_term_a),
        .tc_pulse(tc_pulse_a), .done(done_a)
    );

    iter_counter #(.WIDTH(3), .N_REQ(2), .TERM(5), .SAT(CNT_SAT)) u_sat (
        .clk(clk), .rst(rst), .clr(clr_b), .load(load_b), .load_val(load_val_b),
        .req(req_b), .dn(dn_b), .cnt(cnt_b), .at_term(at_term_b),
        .tc_pulse(tc_pulse_b), .done(done_b)
    );

    // Rising edges at 10, 20, 30 ... so a 25 ns reset release falls mid-cycle.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int c, input int at, input int tc, input int dn);
        check({tag, ".cnt"},      32'(cnt_a),      32'(c));
        check({tag, ".at_term"},  32'(at_term_a),  32'(at));
        check({tag, ".tc_pulse"}, 32'(tc_pulse_a), 32'(tc));
        check({tag, ".done"},     32'(done_a),     32'(dn));
    endtask

    task automatic check_b(input string tag, input int c, input int at, input int tc, input int dn);
        check({tag, ".cnt"},      32'(cnt_b),      32'(c));
        check({tag, ".at_term"},  32'(at_term_b),  32'(at));
        check({tag, ".tc_pulse"}, 32'(tc_pulse_b), 32'(tc));
        check({tag, ".done"},     32'(done_b),     32'(dn));
    endtask

    // Hand-computed responses: up-wrap from 0 (9 steps) and saturate to 5 (8 steps).
    int wrap_cnt [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int wrap_tc  [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    int wrap_dn  [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    int sat_cnt  [8] = '{1, 2, 3, 4, 5, 5, 5, 5};
    int sat_tc   [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int sat_dn   [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    initial begin
        rst = 1'b0;
        clr_a = 1'b0; load_a = 1'b0; dn_a = 1'b0; load_val_a = 3'd0; req_a = 2'b00;
        clr_b = 1'b0; load_b = 1'b0; dn_b = 1'b0; load_val_b = 3'd0; req_b = 2'b00;

        #25;
        check_a("reset_a", 0, 0, 0, 0);
        check_b("reset_b", 0, 0, 0, 0);
        rst = 1'b1;

        // Up-count with wrap through TERM=7.
        req_a = 2'b01;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_a($sformatf("upwrap[%0d]", i), wrap_cnt[i], (wrap_cnt[i] == 7) ? 1 : 0,
                    wrap_tc[i], wrap_dn[i]);
        end

        // Idle: count holds.
        req_a = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check_a("idle", 1, 0, 0, 1);

        // Three steps to 4, then clr beats load and step.
        req_a = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check_a("to4", 4, 0, 0, 1);
        clr_a = 1'b1; load_a = 1'b1; load_val_a = 3'd6; req_a = 2'b01;
        tick();
        check_a("clr_prio", 0, 0, 0, 0);
        clr_a = 1'b0; load_a = 1'b0;

        // Both request lines high still count one step per cycle.
        req_a = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check_a("multireq", 3, 0, 0, 0);

        // Load TERM with a step pending: load wins, no pulse, no done.
        load_a = 1'b1; load_val_a = 3'd7; req_a = 2'b01;
        tick();
        check_a("load_term", 7, 1, 0, 0);

        // Down-wrap: load 1, then 1 -> 0 -> 7 with a pulse on the wrap.
        load_val_a = 3'd1; req_a = 2'b00;
        tick();
        check_a("load1", 1, 0, 0, 0);
        load_a = 1'b0; dn_a = 1'b1; req_a = 2'b01;
        tick();
        check_a("down0", 0, 0, 0, 0);
        tick();
        check_a("downwrap", 7, 1, 1, 1);
        tick();
        check_a("down6", 6, 0, 0, 1);
        tick();
        check_a("down5", 5, 0, 0, 1);

        // Saturate instance: stop at TERM=5 with a single pulse.
        req_a = 2'b00;
        req_b = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_b($sformatf("sat[%0d]", i), sat_cnt[i], (sat_cnt[i] == 5) ? 1 : 0,
                    sat_tc[i], sat_dn[i]);
        end
        check_a("a_idle_during_b", 5, 0, 0, 1);

        // Loaded above TERM: count on to all-ones and hold there.
        load_b = 1'b1; load_val_b = 3'd6;
        tick();
        check_b("sat_load6", 6, 0, 0, 0);
        load_b = 1'b0;
        tick();
        check_b("sat_7", 7, 0, 0, 0);
        tick();
        check_b("sat_hold7", 7, 0, 0, 0);

        // Down at 0 in saturate mode holds at 0.
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0; dn_b = 1'b1;
        tick();
        check_b("sat_down0", 0, 0, 0, 0);
        req_b = 2'b00; dn_b = 1'b0;

        // Async reset between edges with cnt=5, done=1.
        req_a = 2'b01; dn_a = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_a("async_rst", 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        tick();
        check_a("post_rst", 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_counter.md
Name: iter_counter

Overview:
- Parametrised iteration counter for the ALU control unit; successor to the fixed 3-bit "count-to-7" counter.
- Counts steps requested by any of N_REQ control lines and flags arrival at a programmable terminal count.
- Adds synchronous clear, parallel load, up/down direction, a wrap or saturate mode, a one-cycle terminal pulse and a sticky done flag.
- Drives loop termination for multi-cycle multiply/divide sequences.

Parameters:
- WIDTH, 3: counter width in bits.
- N_REQ, 2: number of step-request lines, OR-combined.
- TERM, 7: terminal count; must satisfy 0 < TERM <= 2^WIDTH-1.
- SAT, 0: 0 = wrap mode, 1 = saturate mode.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- req  in  N_REQ  step requests; a step occurs when any bit is 1.
- dn  in  1  direction: 0 = up, 1 = down.
- cnt  out  WIDTH  current count, registered.
- at_term  out  1  combinational; 1 when cnt == TERM.
- tc_pulse  out  1  registered; one-cycle pulse on a counting step into TERM.
- done  out  1  registered sticky terminal flag.

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, tc_pulse=0, done=0. at_term follows cnt (0, since TERM>0).
- Synchronous priority per edge: clr > load > step > hold.
- clr: cnt<=0, done<=0, tc_pulse<=0.
- load: cnt<=load_val, done<=0, tc_pulse<=0.
  - Loading a value equal to TERM sets at_term but does not pulse or set done.
  - If load_val > TERM, the counter still counts normally. Up-count wraps via all-ones to 0 (or holds at all-ones in SAT mode); it is not forced to TERM.
- step = |req, when not clr or load:
  - Up, cnt != TERM: cnt<=cnt+1 (mod 2^WIDTH).
  - Up, cnt == TERM: wrap mode cnt<=0; SAT mode cnt holds.
  - Down, cnt != 0: cnt<=cnt-1.
  - Down, cnt == 0: wrap mode cnt<=TERM; SAT mode holds at 0.
- tc_pulse<=1 exactly when a step changes cnt to TERM (the next cnt equals TERM and the current cnt does not). Otherwise tc_pulse<=0.
  - A saturated hold at TERM gives no repeated pulse.
  - A down-wrap 0->TERM does pulse.
- done<=1 when tc_pulse is being set. done holds 1 until clr or load.
- Multiple req bits high in the same cycle still count one step; no multi-step counting.
- Latency:
  - cnt, tc_pulse and done update 1 cycle after the enabling edge.
  - at_term has zero latency from cnt.
- Reset asserted mid-count: immediate return to reset values, independent of clk. Counting resumes on the first edge after rst deasserts.

Decomposition:
- Shared package alu_ctrl_pkg holds the mode constants CNT_WRAP=0 and CNT_SAT=1 and the default loop-count constants used by the multiply/divide sequencers.
- No sub-module needed. Next-count logic is one always block plus one registered flag block.
- The existing toggle-cell counter structure is not reused, because parallel load and down-count require a D-register next-state form.

Test Plan:
- Reset and up-wrap (WIDTH=3, TERM=7, SAT=0):
  - Stimulus: rst low for 25 ns, then req=2'b01 held for 9 cycles.
  - Required: cnt 0..7; at_term=1 only at cnt=7; tc_pulse high one cycle coincident with cnt=7; done=1 from then on; next cnt=0.
- Idle and multi-request:
  - req=2'b00 for 5 cycles -> cnt holds.
  - req=2'b11 for 3 cycles from 0 -> cnt=3, not 6.
- Saturate (SAT=1, TERM=5):
  - Stimulus: up-step 8 cycles from 0.
  - Required: cnt stops at 5; tc_pulse exactly once; done=1; at_term stays 1.
- Down-wrap (SAT=0, TERM=7):
  - Load 1, then dn=1 with 2 steps.
  - Required: cnt 1->0->7; tc_pulse on the 0->7 transition.
- Priority:
  - clr=1, load=1, req=1 in the same cycle at cnt=4 -> cnt=0, done=0.
  - load=1 with load_val=7 and req=1 -> cnt=7, tc_pulse=0, done=0.
- Async reset mid-count:
  - Drop rst between edges at cnt=5 with done=1.
  - Required: cnt=0 and done=0 immediately, before the next edge.
